stream_mux_n_to_1: RTL and testbench

// - Parametrised N-channel, W-bit successor to the 4-to-1 gate-level mux.
// - Adds per-channel valid/ready handshakes and a registered output stage.
// - Adds two selection modes: external select, or round-robin fairness.
// - Sits between several producer streams and one consumer (e.g. a shared display or UART path).

---
 rtl/stream_mux_n_to_1_pkg.sv | 27 ++
 rtl/stream_mux_n_to_1_if.sv | 29 ++
 rtl/stream_mux_n_to_1_rr_arbiter.sv | 27 ++
 rtl/stream_mux_n_to_1.sv | 110 +++++++++++
 tb/tb_stream_mux_n_to_1.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_n_to_1_pkg.sv
// Shared definitions for the N-to-1 stream multiplexer: mode encoding and
// the width helper used to size channel indices.
package stream_mux_n_to_1_pkg;

    typedef enum logic {
        MODE_SELECT = 1'b0,
        MODE_RR     = 1'b1
    } mux_mode_e;

    localparam int MUX_DEFAULT_N = 4;
    localparam int MUX_DEFAULT_W = 8;

    // Smallest r with 2**r >= value; clamps to 1 so a 2-channel build still has a 1-bit index.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_mux_n_to_1_if.sv
// Bundle of producer-side and consumer-side stream signals plus the
// selection controls of the N-to-1 stream multiplexer.
interface stream_mux_n_to_1_if #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = 2
);
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_chan;
    logic             out_ready;

    // Environment view: drives producers, controls and the consumer ready.
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    // Multiplexer view.
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/stream_mux_n_to_1_rr_arbiter.sv
// Combinational rotate-priority arbiter: the search starts one past ptr and
// wraps modulo N, so the most recently served channel has lowest priority.
module stream_mux_n_to_1_rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    logic [SEL_W-1:0] idx_s;

    // Walk from the farthest candidate to the nearest so the nearest requester wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = {SEL_W{1'b0}};
        idx_s     = {SEL_W{1'b0}};
        for (int k = N; k >= 1; k--) begin
            idx_s     = SEL_W'((int'(ptr) + k) % N);
            gnt_valid = gnt_valid | req[idx_s];
            gnt_idx   = req[idx_s] ? idx_s : gnt_idx;
        end
    end

endmodule

// File: rtl/stream_mux_n_to_1.sv
// N-channel, W-bit stream multiplexer with valid/ready handshakes, a one-deep
// registered output stage, and external-select or round-robin channel choice.
module stream_mux_n_to_1
    import stream_mux_n_to_1_pkg::*;
#(
    parameter int N     = MUX_DEFAULT_N,
    parameter int W     = MUX_DEFAULT_W,
    parameter int SEL_W = clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    stream_mux_n_to_1_if.slave  mux
);

    mux_mode_e        mode_s;
    logic             load_en_s;
    logic             sel_valid_s;
    logic             arb_valid_s;
    logic [SEL_W-1:0] arb_idx_s;
    logic             grant_valid_s;
    logic [SEL_W-1:0] grant_idx_s;
    logic [W-1:0]     grant_data_s;
    logic [N-1:0]     in_ready_s;

    logic             out_valid_r;
    logic [W-1:0]     out_data_r;
    logic [SEL_W-1:0] out_chan_r;
    logic [SEL_W-1:0] rr_ptr_r;

    assign mode_s    = mux_mode_e'(mux.mode);
    assign load_en_s = !out_valid_r || mux.out_ready;

    stream_mux_n_to_1_rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req       (mux.in_valid),
        .ptr       (rr_ptr_r),
        .gnt_valid (arb_valid_s),
        .gnt_idx   (arb_idx_s)
    );

    // External select: out-of-range indices match no channel, so they never grant.
    always_comb begin
        sel_valid_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            sel_valid_s = sel_valid_s | ((mux.sel == SEL_W'(i)) & mux.in_valid[i]);
        end
    end

    // Mode mux between the external select and the arbiter result.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {SEL_W{1'b0}};
        case (mode_s)
            MODE_SELECT: begin
                grant_valid_s = sel_valid_s;
                grant_idx_s   = mux.sel;
            end
            MODE_RR: begin
                grant_valid_s = arb_valid_s;
                grant_idx_s   = arb_idx_s;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_idx_s   = {SEL_W{1'b0}};
            end
        endcase
    end

    // Data-select mux and one-hot ready back to the granted producer.
    always_comb begin
        grant_data_s = {W{1'b0}};
        in_ready_s   = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            grant_data_s  = (grant_idx_s == SEL_W'(i)) ? mux.in_data[i*W +: W] : grant_data_s;
            in_ready_s[i] = load_en_s && grant_valid_s && (grant_idx_s == SEL_W'(i));
        end
    end

    // Output register: loads on every free slot; an empty grant leaves data/chan untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {W{1'b0}};
            out_chan_r  <= {SEL_W{1'b0}};
        end else if (load_en_s) begin
            out_valid_r <= grant_valid_s;
            if (grant_valid_s) begin
                out_data_r <= grant_data_s;
                out_chan_r <= grant_idx_s;
            end
        end
    end

    // Round-robin pointer: only round-robin transfers move it; select-mode traffic leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= SEL_W'(N - 1);
        end else if (load_en_s && grant_valid_s && (mode_s == MODE_RR)) begin
            rr_ptr_r <= grant_idx_s;
        end
    end

    assign mux.in_ready  = in_ready_s;
    assign mux.out_valid = out_valid_r;
    assign mux.out_data  = out_data_r;
    assign mux.out_chan  = out_chan_r;

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// Scoreboard bench for stream_mux_n_to_1: a 4-channel and a 3-channel build,
// expected words queued at stimulus time and popped on each output handshake.
module tb_stream_mux_n_to_1;

    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;
    exp_t q4[$];
    exp_t q3[$];
    logic [7:0] d4 [4];
    logic [7:0] d3 [3];

    stream_mux_n_to_1_if #(.N(4), .W(8), .SEL_W(2)) m4 ();
    stream_mux_n_to_1_if #(.N(3), .W(8), .SEL_W(2)) m3 ();

    stream_mux_n_to_1 #(.N(4), .W(8), .SEL_W(2)) dut4 (.clk(clk), .rst(rst), .mux(m4));
    stream_mux_n_to_1 #(.N(3), .W(8), .SEL_W(2)) dut3 (.clk(clk), .rst(rst), .mux(m3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitor, 4-channel build.
    always @(negedge clk) begin
        if (!rst && m4.out_valid && m4.out_ready) begin
            if (q4.size() == 0) begin
                check_val("sb4_unexpected_word", 32'(q4.size()), 32'd1);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check_val("sb4_chan", 32'(m4.out_chan), 32'(e.chan));
                check_val("sb4_data", 32'(m4.out_data), 32'(e.data));
            end
        end
    end

    // Output monitor, 3-channel build.
    always @(negedge clk) begin
        if (!rst && m3.out_valid && m3.out_ready) begin
            if (q3.size() == 0) begin
                check_val("sb3_unexpected_word", 32'(q3.size()), 32'd1);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check_val("sb3_chan", 32'(m3.out_chan), 32'(e.chan));
                check_val("sb3_data", 32'(m3.out_data), 32'(e.data));
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        d4[0] = 8'hA0; d4[1] = 8'hA1; d4[2] = 8'hA2; d4[3] = 8'hA3;
        d3[0] = 8'hC0; d3[1] = 8'hC1; d3[2] = 8'hC2;
        rst = 1'b1;
        m4.mode = 1'b0; m4.sel = 2'd0; m4.in_valid = 4'b0000; m4.out_ready = 1'b0;
        m4.in_data = {d4[3], d4[2], d4[1], d4[0]};
        m3.mode = 1'b0; m3.sel = 2'd0; m3.in_valid = 3'b000; m3.out_ready = 1'b0;
        m3.in_data = {d3[2], d3[1], d3[0]};
        #2;
        check_val("rst_out_valid", 32'(m4.out_valid), 32'd0);
        check_val("rst_out_data", 32'(m4.out_data), 32'd0);
        check_val("rst_out_chan", 32'(m4.out_chan), 32'd0);
        check_val("rst_in_ready", 32'(m4.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // SELECT sweep, all valid, consumer always ready.
        m4.mode = 1'b0; m4.in_valid = 4'b1111; m4.out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            m4.sel = 2'(s);
            q4.push_back({2'(s), d4[s]});
            #1;
            check_val("sel_in_ready", 32'(m4.in_ready), 32'(4'b0001 << s));
            step();
        end
        m4.in_valid = 4'b0000;
        step();
        step();
        check_val("sel_drain_valid", 32'(m4.out_valid), 32'd0);

        // SELECT pointing at an invalid channel drops out_valid, keeps data/chan.
        m4.sel = 2'd0; m4.in_valid = 4'b1111;
        q4.push_back({2'd0, d4[0]});
        step();
        m4.in_valid = 4'b1101; m4.sel = 2'd1;
        #1;
        check_val("sel_invalid_ready", 32'(m4.in_ready), 32'd0);
        step();
        check_val("sel_invalid_valid", 32'(m4.out_valid), 32'd0);
        check_val("sel_invalid_hold_data", 32'(m4.out_data), 32'(d4[0]));
        check_val("sel_invalid_hold_chan", 32'(m4.out_chan), 32'd0);
        m4.in_valid = 4'b0000;

        // Reset while a word is held: cleared immediately, before any clock edge.
        m4.out_ready = 1'b0; m4.in_valid = 4'b1111; m4.sel = 2'd2;
        q4.push_back({2'd2, d4[2]});
        step();
        m4.in_valid = 4'b0000;
        #1;
        check_val("pre_rst_valid", 32'(m4.out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_val("mid_rst_out_valid", 32'(m4.out_valid), 32'd0);
        check_val("mid_rst_out_data", 32'(m4.out_data), 32'd0);
        check_val("mid_rst_out_chan", 32'(m4.out_chan), 32'd0);
        q4.delete();
        @(negedge clk);
        rst = 1'b0;
        step();

        // ROUND_ROBIN, all valid: 0,1,2,3,0,... back to back, starting at channel 0.
        m4.mode = 1'b1; m4.in_valid = 4'b1111; m4.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q4.push_back({2'(i % 4), d4[i % 4]});
            #1;
            check_val("rr_in_ready", 32'(m4.in_ready), 32'(4'b0001 << (i % 4)));
            if (i > 0) begin
                check_val("rr_back_to_back", 32'(m4.out_valid), 32'd1);
            end
            step();
        end
        m4.in_valid = 4'b0000;
        step();
        step();

        // ROUND_ROBIN with 1010 and a 3-cycle consumer stall.
        m4.out_ready = 1'b0; m4.in_valid = 4'b1010;
        q4.push_back({2'd1, d4[1]});
        #1;
        check_val("rr_stall_first_ready", 32'(m4.in_ready), 32'b0010);
        step();
        for (int c = 0; c < 3; c++) begin
            check_val("stall_valid", 32'(m4.out_valid), 32'd1);
            check_val("stall_data", 32'(m4.out_data), 32'(d4[1]));
            check_val("stall_chan", 32'(m4.out_chan), 32'd1);
            check_val("stall_in_ready", 32'(m4.in_ready), 32'd0);
            step();
        end
        m4.out_ready = 1'b1;
        q4.push_back({2'd3, d4[3]});
        #1;
        check_val("rr_after_stall_ready3", 32'(m4.in_ready), 32'b1000);
        step();
        q4.push_back({2'd1, d4[1]});
        #1;
        check_val("rr_after_stall_ready1", 32'(m4.in_ready), 32'b0010);
        step();
        m4.in_valid = 4'b0000;
        step();
        step();

        // A SELECT-mode transfer must not move the round-robin pointer (still at 1).
        m4.mode = 1'b0; m4.sel = 2'd3; m4.in_valid = 4'b1111;
        q4.push_back({2'd3, d4[3]});
        step();
        m4.mode = 1'b1;
        q4.push_back({2'd2, d4[2]});
        #1;
        check_val("rr_ptr_kept_ready", 32'(m4.in_ready), 32'b0100);
        step();
        m4.in_valid = 4'b0000;
        step();
        step();

        // N=3 build: round robin wraps 2 -> 0.
        m3.mode = 1'b1; m3.in_valid = 3'b111; m3.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q3.push_back({2'(i % 3), d3[i % 3]});
            #1;
            check_val("n3_rr_in_ready", 32'(m3.in_ready), 32'(3'b001 << (i % 3)));
            step();
        end
        m3.in_valid = 3'b000;
        step();
        step();

        // N=3 build: sel=3 is out of range and never grants.
        m3.mode = 1'b0; m3.sel = 2'd3; m3.in_valid = 3'b111;
        #1;
        check_val("n3_sel_oob_ready", 32'(m3.in_ready), 32'd0);
        step();
        check_val("n3_sel_oob_valid", 32'(m3.out_valid), 32'd0);
        m3.in_valid = 3'b000;
        step();

        check_val("sb4_leftover", 32'(q4.size()), 32'd0);
        check_val("sb3_leftover", 32'(q3.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
